// File: rtl/cpu_pkg.sv
// Shared definitions for the single-issue MIPS core front end.
// Contents:
//   fetch_state_t    - state encoding of the instruction fetch FSM
//   WORD_BYTES       - bytes per instruction word
//   DEFAULT_RESET_PC - default PC loaded on reset
//   is_word_aligned  - true when an address is on a word boundary
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_FAULT
  } fetch_state_t;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK       = 32'(WORD_BYTES - 1);

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr & ALIGN_MASK) == 32'h0;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Architectural PC register.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset, loads RESET_PC
//   load  - load enable; q takes d on the next rising edge
//   d     - next PC value
//   q     - current PC
module pc_register
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time over
// a valid/ready request channel, holds the returned instruction with its PC
// for decode, and loads the next PC returned by the branch/jump logic.
// Ports:
//   clk, reset                         - clock and synchronous active-high reset
//   imem_req_valid/ready/addr          - fetch request channel (addr == PC)
//   imem_resp_valid/data               - returned instruction word
//   out_valid/ready/instruction/pc     - fetched instruction to decode
//   next_pc                            - next PC, sampled on the out handshake
//   misaligned                         - sticky fault on a misaligned next_pc
//   retired                            - count of accepted instructions (wraps)
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  input  logic [31:0] next_pc,
  output logic        misaligned,
  output logic [31:0] retired
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         handshake;
  logic         pc_load;

  // out_valid is high exactly while in HOLD, so it qualifies the handshake.
  assign handshake = out_valid & out_ready;
  // A misaligned target leaves the PC pointing at the faulting instruction.
  assign pc_load   = handshake & is_word_aligned(next_pc);

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk  (clk),
    .reset(reset),
    .load (pc_load),
    .d    (next_pc),
    .q    (pc)
  );

  // The PC only moves on the out handshake, so it is both the stable fetch
  // address and the PC of the instruction being held.
  assign imem_req_addr = pc;
  assign out_pc        = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      imem_req_valid  <= 1'b0;
      out_valid       <= 1'b0;
      out_instruction <= 32'h0;
      misaligned      <= 1'b0;
      retired         <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          state          <= ST_FETCH;
          imem_req_valid <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_req_ready) begin
            state          <= ST_WAIT;
            imem_req_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            state           <= ST_HOLD;
            out_instruction <= imem_resp_data;
            out_valid       <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            retired   <= retired + 32'd1;
            if (is_word_aligned(next_pc)) begin
              state          <= ST_FETCH;
              imem_req_valid <= 1'b1;
            end else begin
              state      <= ST_FAULT;
              misaligned <= 1'b1;
            end
          end
        end
        ST_FAULT: begin
          // Parked until reset.
          state <= ST_FAULT;
        end
        default: begin
          state          <= ST_IDLE;
          imem_req_valid <= 1'b0;
          out_valid      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: a memory model and a downstream model drive the
// DUT; expected fetch addresses and expected (pc, instruction) outputs are
// queued by the directed sequence and popped by an independent monitor.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic [31:0] next_pc;
  logic        misaligned;
  logic [31:0] retired;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_pc         (out_pc),
    .next_pc        (next_pc),
    .misaligned     (misaligned),
    .retired        (retired)
  );

  // Downstream next-PC logic: sequential unless a jump target is forced.
  logic        jump_en;
  logic [31:0] jump_target;
  assign next_pc = jump_en ? jump_target : out_pc + 32'd4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_event(input string name, input logic [31:0] act);
    total_cnt++;
    $display("FAIL %s: got unexpected event with value %h, expected none", name, act);
  endtask

  // Scoreboard queues.
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];

  task automatic push_out(input logic [31:0] pc, input logic [31:0] instr);
    exp_pc_q.push_back(pc);
    exp_instr_q.push_back(instr);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!reset && imem_req_valid && imem_req_ready) begin
      if (exp_addr_q.size() == 0) fail_event("req_accept", imem_req_addr);
      else check("req_accept_addr", imem_req_addr, exp_addr_q.pop_front());
    end
    if (!reset && out_valid && out_ready) begin
      if (exp_pc_q.size() == 0) fail_event("out_handshake", out_instruction);
      else begin
        check("out_pc", out_pc, exp_pc_q.pop_front());
        check("out_instruction", out_instruction, exp_instr_q.pop_front());
      end
    end
  end

  // Memory model: drives its outputs 2 time units after each rising edge.
  logic        gate;
  int          lat;
  logic [31:0] word;
  logic        spur;
  logic [31:0] spur_data;
  logic        pending = 1'b0;
  int          cnt = 0;
  logic        real_resp;

  always begin
    @(posedge clk);
    #2;
    if (reset) begin
      pending         = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = spur;
      imem_resp_data  = spur_data;
    end else begin
      real_resp = 1'b0;
      if (pending) begin
        cnt--;
        if (cnt == 0) begin
          real_resp = 1'b1;
          pending   = 1'b0;
        end
      end
      imem_req_ready = imem_req_valid && gate;
      if (imem_req_ready) begin
        pending = 1'b1;
        cnt     = lat;
      end
      imem_resp_valid = real_resp | spur;
      imem_resp_data  = spur ? spur_data : word;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; jump_en = 1'b0; jump_target = 32'h0;
    gate = 1'b1; lat = 1; word = 32'h2002_0005; spur = 1'b0; spur_data = 32'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;

    tick(); tick();
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);  // cycle 1: IDLE
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_instruction", out_instruction, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_misaligned", {31'h0, misaligned}, 32'h0);
    check("rst_retired", retired, 32'h0);

    // Zero-wait sequential fetch: requests in cycles 2, 5, 8 (and 11).
    exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8); exp_addr_q.push_back(32'hC);
    push_out(32'h0, 32'h2002_0005); push_out(32'h4, 32'h2002_0005);
    push_out(32'h8, 32'h2002_0005);
    for (int k = 2; k <= 11; k++) begin
      tick();
      if (k == 10) gate = 1'b0;
      @(negedge clk);
      check($sformatf("seq_req_valid_c%0d", k), {31'h0, imem_req_valid},
            (k == 2 || k == 5 || k == 8 || k == 11) ? 32'h1 : 32'h0);
    end
    check("seq_retired", retired, 32'd3);
    check("seq_addr_c11", imem_req_addr, 32'hC);

    // Stalled request, then response two cycles after acceptance.
    for (int k = 12; k <= 14; k++) begin
      tick();
      @(negedge clk);
      check("stall_addr", imem_req_addr, 32'hC);
      check("stall_req_valid", {31'h0, imem_req_valid}, 32'h1);
    end
    tick();  // cycle 15
    gate = 1'b1; lat = 2; word = 32'h8C22_0004;
    push_out(32'hC, 32'h8C22_0004);
    @(negedge clk);
    check("accept_addr", imem_req_addr, 32'hC);
    tick();  // cycle 16
    @(negedge clk);
    check("wait1_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("wait1_out_valid", {31'h0, out_valid}, 32'h0);
    tick();  // cycle 17
    @(negedge clk);
    check("wait2_resp_valid", {31'h0, imem_resp_valid}, 32'h1);
    check("wait2_out_valid", {31'h0, out_valid}, 32'h0);
    tick();  // cycle 18
    out_ready = 1'b0;
    @(negedge clk);
    check("hold_out_valid", {31'h0, out_valid}, 32'h1);
    check("hold_out_instruction", out_instruction, 32'h8C22_0004);

    // Back-pressure in HOLD with a spurious response.
    for (int k = 19; k <= 22; k++) begin
      tick();
      spur = (k == 19); spur_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check("bp_out_instruction", out_instruction, 32'h8C22_0004);
      check("bp_req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("bp_retired", retired, 32'd3);
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
    end

    // Jump to 0x0040_0010.
    tick();  // cycle 23
    out_ready = 1'b1; jump_en = 1'b1; jump_target = 32'h0040_0010;
    exp_addr_q.push_back(32'h0040_0010);
    @(negedge clk);
    tick();  // cycle 24
    lat = 1; word = 32'h0800_0000; jump_target = 32'h0000_0006;
    push_out(32'h0040_0010, 32'h0800_0000);
    @(negedge clk);
    check("jump_addr", imem_req_addr, 32'h0040_0010);
    check("jump_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("jump_retired", retired, 32'd4);
    tick(); @(negedge clk);  // cycle 25
    tick(); @(negedge clk);  // cycle 26
    check("pre_fault_out_valid", {31'h0, out_valid}, 32'h1);

    // Misaligned next_pc: FAULT, no further requests.
    for (int k = 27; k <= 30; k++) begin
      tick();
      @(negedge clk);
      check("fault_misaligned", {31'h0, misaligned}, 32'h1);
      check("fault_req_valid", {31'h0, imem_req_valid}, 32'h0);
      check("fault_out_valid", {31'h0, out_valid}, 32'h0);
      check("fault_retired", retired, 32'd5);
      check("fault_pc_held", out_pc, 32'h0040_0010);
    end

    // Reset leaves FAULT.
    tick();  // cycle 31
    reset = 1'b1; jump_en = 1'b0;
    @(negedge clk);
    tick();  // cycle 32: IDLE
    reset = 1'b0; lat = 10;
    exp_addr_q.push_back(32'h0);
    @(negedge clk);
    check("clr_misaligned", {31'h0, misaligned}, 32'h0);
    check("clr_retired", retired, 32'h0);
    check("clr_out_pc", out_pc, 32'h0);
    check("clr_req_valid", {31'h0, imem_req_valid}, 32'h0);
    tick();  // cycle 33: FETCH, accepted
    @(negedge clk);
    check("refetch_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("refetch_addr", imem_req_addr, 32'h0);

    // Reset in WAIT, stale response in the first FETCH after reset.
    tick();  // cycle 34: WAIT
    reset = 1'b1;
    @(negedge clk);
    check("wait_req_valid", {31'h0, imem_req_valid}, 32'h0);
    tick();  // cycle 35: IDLE
    reset = 1'b0; lat = 1; word = 32'h2402_0001;
    exp_addr_q.push_back(32'h0);
    push_out(32'h0, 32'h2402_0001);
    @(negedge clk);
    check("rst2_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst2_req_valid", {31'h0, imem_req_valid}, 32'h0);
    tick();  // cycle 36: FETCH with stale response
    spur = 1'b1; spur_data = 32'hBAD0_BAD0;
    @(negedge clk);
    check("stale_req_valid", {31'h0, imem_req_valid}, 32'h1);
    check("stale_addr", imem_req_addr, 32'h0);
    tick();  // cycle 37: WAIT
    spur = 1'b0;
    @(negedge clk);
    check("stale_discarded", {31'h0, out_valid}, 32'h0);
    tick();  // cycle 38: HOLD
    gate = 1'b0;
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    @(negedge clk);
    check("rst2_out_valid_hold", {31'h0, out_valid}, 32'h1);
    check("rst2_out_instruction", out_instruction, 32'h2402_0001);
    check("preload_retired", retired, 32'hFFFF_FFFF);
    tick();  // cycle 39
    @(negedge clk);
    check("wrap_retired", retired, 32'h0);
    check("wrap_addr", imem_req_addr, 32'h4);
    tick();
    @(negedge clk);
    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'h0);
    check("out_queue_drained", 32'(exp_pc_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the single-issue MIPS core. It owns the architectural PC register and issues word fetches to instruction memory over a valid/ready request channel. It presents each returned instruction with its PC to decode and the next-PC logic, then loads the next PC that the branch/jump logic computes. It sits on the opposite side of the next-PC datapath: the branch/jump logic consumes `out_pc` and `out_instruction`, and this block consumes the `next_pc` it returns.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset. Must be word-aligned.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `imem_req_valid`, out, 1: fetch request valid.
- `imem_req_ready`, in, 1: memory accepts the request this cycle.
- `imem_req_addr`, out, 32: byte address of the fetch. Always equals the PC.
- `imem_resp_valid`, in, 1: instruction word returned this cycle.
- `imem_resp_data`, in, 32: returned instruction word.
- `out_valid`, out, 1: `out_instruction`/`out_pc` hold a fetched instruction.
- `out_ready`, in, 1: downstream accepts; `next_pc` is valid in this cycle.
- `out_instruction`, out, 32: fetched instruction.
- `out_pc`, out, 32: PC of `out_instruction`.
- `next_pc`, in, 32: next PC from the branch/jump logic. Sampled only on the out handshake.
- `misaligned`, out, 1: sticky fault flag.
- `retired`, out, 32: count of accepted instructions.

## Operation
- FSM states: IDLE, FETCH, WAIT, HOLD, FAULT.
- IDLE: all valids are 0. Unconditionally moves to FETCH on the next cycle.
- FETCH: `imem_req_valid`=1. If `imem_req_ready`=1, go to WAIT. Otherwise stay in FETCH with address held.
- WAIT: `imem_req_valid`=0. On `imem_resp_valid`=1, capture `imem_resp_data` into the instruction register and go to HOLD.
- `imem_resp_valid` is ignored in every state except WAIT.
- HOLD: `out_valid`=1. `out_instruction` and `out_pc` stay stable until the handshake (`out_valid & out_ready`). On the handshake:
  - If `next_pc[1:0]`==0: PC <= `next_pc`, `retired` <= `retired`+1, go to FETCH.
  - Otherwise: PC is unchanged, `retired` still increments, `misaligned` <= 1, go to FAULT.
- FAULT: all valids are 0. The only exit is `reset`.
- `retired` wraps from `32'hFFFF_FFFF` to 0.
- PC arithmetic is full 32-bit; no wrap check is made on `next_pc`.
- Reset values, and the state after any cycle with `reset`=1 in any state:
  - state IDLE, PC=`RESET_PC`
  - `imem_req_valid`=0, `out_valid`=0
  - `out_instruction`=0, `out_pc`=`RESET_PC`
  - `misaligned`=0, `retired`=0
- Reset mid-operation:
  - An outstanding request or response is abandoned.
  - Instruction memory shares the same `reset` and must drop in-flight responses.
  - A response arriving in IDLE or FETCH is discarded.

## Timing
- Zero-wait memory (ready=1 in FETCH, response in the first WAIT cycle, out_ready=1): 3 cycles per instruction, in the sequence FETCH, WAIT, HOLD.
- First request is asserted 2 cycles after reset deasserts (reset cycle, then IDLE, then FETCH).
- `imem_req_addr` is stable from request assertion through acceptance.
- Request and response are never both accepted in the same cycle; at most one request is outstanding.
- `out_*` are registered; there is no combinational path from `imem_resp_*` to `out_*`.
- `next_pc` may depend combinationally on `out_pc`/`out_instruction`. There is no combinational path from `next_pc` or `out_ready` to any output.

## Structure
- Shared package `cpu_pkg`:
  - FSM state enum `fetch_state_t`
  - constants `WORD_BYTES`=4 and `DEFAULT_RESET_PC`
- One natural sub-module, `pc_register`: the PC register with a synchronous reset to `RESET_PC` and a load enable. Everything else stays in `instr_fetch`.

## Test plan
- Reset, then zero-wait memory returning `32'h2002_0005`, out_ready=1, next_pc=`out_pc`+4 → addresses 0, 4, 8 in cycles 2, 5, 8 after reset release; `retired`=3 after the third HOLD.
- Memory holds `imem_req_ready`=0 for 4 cycles, then responds 2 cycles after acceptance → `imem_req_addr` stable throughout; `out_valid` rises exactly one cycle after `imem_resp_valid`.
- out_ready=0 for 5 cycles in HOLD, with a spurious `imem_resp_valid` injected → `out_instruction` unchanged, no new request, `retired` unchanged.
- Jump: at handshake `next_pc`=`32'h0040_0010` → next request address is `32'h0040_0010`.
- Handshake with `next_pc`=`32'h0000_0006` → `misaligned`=1, FSM in FAULT, no further requests; `reset` clears the fault and the next fetch is from `RESET_PC`.
- Reset asserted in WAIT, and the stale response lands in the first FETCH cycle after reset → response discarded; the fetch restarts at `RESET_PC`; preload `retired`=`32'hFFFF_FFFF` (force), one accept → `retired`=0.
